// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with freeze (hold), flush and bubble insertion, plus a
// saturating count of cycles in which EX held a bubble.
module id_ex_stage_reg #(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    idValid,
    input  logic [31:0]             pcIn,
    input  logic [31:0]             reg1ValIn,
    input  logic [31:0]             reg2ValIn,
    input  logic                    immediateIn,
    input  logic [11:0]             shiftOperandIn,
    input  logic [23:0]             signedImm24In,
    input  logic [3:0]              aluCmdIn,
    input  logic                    memReadIn,
    input  logic                    memWriteIn,
    input  logic                    wbEnableIn,
    input  logic                    branchIn,
    input  logic                    statusUpdateIn,
    input  logic [3:0]              destIn,
    input  logic [3:0]              src1In,
    input  logic [3:0]              src2In,
    input  logic [3:0]              statusIn,
    output logic [31:0]             pcOut,
    output logic [31:0]             reg1ValOut,
    output logic [31:0]             reg2ValOut,
    output logic                    immediateOut,
    output logic [11:0]             shiftOperandOut,
    output logic [23:0]             signedImm24Out,
    output logic [3:0]              aluCmdOut,
    output logic                    memReadOut,
    output logic                    memWriteOut,
    output logic                    wbEnableOut,
    output logic                    branchOut,
    output logic                    statusUpdateOut,
    output logic [3:0]              destOut,
    output logic [3:0]              src1Out,
    output logic [3:0]              src2Out,
    output logic [3:0]              statusOut,
    output logic                    memEnableOut,
    output logic                    validOut,
    output logic [BUBBLE_CNT_W-1:0] bubbleCount
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] reg1_val;
        logic [31:0] reg2_val;
        logic        immediate;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm24;
        logic [3:0]  alu_cmd;
        logic        mem_read;
        logic        mem_write;
        logic        wb_enable;
        logic        branch;
        logic        status_update;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  status;
        logic        mem_enable;
        logic        valid;
    } stage_t;

    stage_t                  stage_q, stage_d;
    logic [BUBBLE_CNT_W-1:0] bubble_q, bubble_d;
    logic                    load_bubble;

    // Flush outranks freeze; an absent decode instruction only bubbles when not frozen.
    assign load_bubble = flush || (!freeze && !idValid);

    always_comb begin
        // NOTE: defaults first so every path assigns stage_d/bubble_d and no latch is inferred.
        stage_d  = stage_q;
        bubble_d = bubble_q;
        if (load_bubble) begin
            stage_d = '0;
            if (bubble_q != '1)
                bubble_d = bubble_q + 1'b1;
        end else if (!freeze) begin
            stage_d.pc            = pcIn;
            stage_d.reg1_val      = reg1ValIn;
            stage_d.reg2_val      = reg2ValIn;
            stage_d.immediate     = immediateIn;
            stage_d.shift_operand = shiftOperandIn;
            stage_d.signed_imm24  = signedImm24In;
            stage_d.alu_cmd       = aluCmdIn;
            stage_d.mem_read      = memReadIn;
            stage_d.mem_write     = memWriteIn;
            stage_d.wb_enable     = wbEnableIn;
            stage_d.branch        = branchIn;
            stage_d.status_update = statusUpdateIn;
            stage_d.dest          = destIn;
            stage_d.src1          = src1In;
            stage_d.src2          = src2In;
            stage_d.status        = statusIn;
            stage_d.mem_enable    = memReadIn | memWriteIn;
            stage_d.valid         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            stage_q  <= '0;
            bubble_q <= '0;
        end else begin
            stage_q  <= stage_d;
            bubble_q <= bubble_d;
        end
    end

    assign pcOut           = stage_q.pc;
    assign reg1ValOut      = stage_q.reg1_val;
    assign reg2ValOut      = stage_q.reg2_val;
    assign immediateOut    = stage_q.immediate;
    assign shiftOperandOut = stage_q.shift_operand;
    assign signedImm24Out  = stage_q.signed_imm24;
    assign aluCmdOut       = stage_q.alu_cmd;
    assign memReadOut      = stage_q.mem_read;
    assign memWriteOut     = stage_q.mem_write;
    assign wbEnableOut     = stage_q.wb_enable;
    assign branchOut       = stage_q.branch;
    assign statusUpdateOut = stage_q.status_update;
    assign destOut         = stage_q.dest;
    assign src1Out         = stage_q.src1;
    assign src2Out         = stage_q.src2;
    assign statusOut       = stage_q.status;
    assign memEnableOut    = stage_q.mem_enable;
    assign validOut        = stage_q.valid;
    assign bubbleCount     = bubble_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized and directed bench for id_ex_stage_reg, checked against a
// record-level model; a second instance with a 3-bit counter covers saturation.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] simm;
        logic [3:0]  alu;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        br;
        logic        su;
        logic [3:0]  dst;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  st;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   freeze, flush, idValid;
    instr_t in_r;

    logic [31:0] pcOut, reg1ValOut, reg2ValOut;
    logic        immediateOut;
    logic [11:0] shiftOperandOut;
    logic [23:0] signedImm24Out;
    logic [3:0]  aluCmdOut, destOut, src1Out, src2Out, statusOut;
    logic        memReadOut, memWriteOut, wbEnableOut, branchOut, statusUpdateOut;
    logic        memEnableOut, validOut;
    logic [15:0] bubbleCount;

    logic [31:0] s_pc, s_r1, s_r2;
    logic        s_imm;
    logic [11:0] s_sh;
    logic [23:0] s_simm;
    logic [3:0]  s_alu, s_dst, s_s1, s_s2, s_st;
    logic        s_mr, s_mw, s_wb, s_br, s_su, s_me, s_v;
    logic [2:0]  s_cnt;

    // Model: what EX holds, whether it is real, and bubble-cycle tallies.
    instr_t exp_ins;
    bit     exp_valid;
    int     exp_cnt16, exp_cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.BUBBLE_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .idValid(idValid),
        .pcIn(in_r.pc), .reg1ValIn(in_r.r1), .reg2ValIn(in_r.r2),
        .immediateIn(in_r.imm), .shiftOperandIn(in_r.sh), .signedImm24In(in_r.simm),
        .aluCmdIn(in_r.alu), .memReadIn(in_r.mr), .memWriteIn(in_r.mw),
        .wbEnableIn(in_r.wb), .branchIn(in_r.br), .statusUpdateIn(in_r.su),
        .destIn(in_r.dst), .src1In(in_r.s1), .src2In(in_r.s2), .statusIn(in_r.st),
        .pcOut(pcOut), .reg1ValOut(reg1ValOut), .reg2ValOut(reg2ValOut),
        .immediateOut(immediateOut), .shiftOperandOut(shiftOperandOut),
        .signedImm24Out(signedImm24Out), .aluCmdOut(aluCmdOut),
        .memReadOut(memReadOut), .memWriteOut(memWriteOut), .wbEnableOut(wbEnableOut),
        .branchOut(branchOut), .statusUpdateOut(statusUpdateOut), .destOut(destOut),
        .src1Out(src1Out), .src2Out(src2Out), .statusOut(statusOut),
        .memEnableOut(memEnableOut), .validOut(validOut), .bubbleCount(bubbleCount)
    );

    id_ex_stage_reg #(.BUBBLE_CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .idValid(idValid),
        .pcIn(in_r.pc), .reg1ValIn(in_r.r1), .reg2ValIn(in_r.r2),
        .immediateIn(in_r.imm), .shiftOperandIn(in_r.sh), .signedImm24In(in_r.simm),
        .aluCmdIn(in_r.alu), .memReadIn(in_r.mr), .memWriteIn(in_r.mw),
        .wbEnableIn(in_r.wb), .branchIn(in_r.br), .statusUpdateIn(in_r.su),
        .destIn(in_r.dst), .src1In(in_r.s1), .src2In(in_r.s2), .statusIn(in_r.st),
        .pcOut(s_pc), .reg1ValOut(s_r1), .reg2ValOut(s_r2),
        .immediateOut(s_imm), .shiftOperandOut(s_sh),
        .signedImm24Out(s_simm), .aluCmdOut(s_alu),
        .memReadOut(s_mr), .memWriteOut(s_mw), .wbEnableOut(s_wb),
        .branchOut(s_br), .statusUpdateOut(s_su), .destOut(s_dst),
        .src1Out(s_s1), .src2Out(s_s2), .statusOut(s_st),
        .memEnableOut(s_me), .validOut(s_v), .bubbleCount(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_ins   = '0;
        exp_valid = 0;
        exp_cnt16 = 0;
        exp_cnt3  = 0;
    endtask

    // One clock edge as seen by the model: flush > freeze > idValid.
    task automatic model_edge();
        if (flush || (!freeze && !idValid)) begin
            exp_ins   = '0;
            exp_valid = 0;
            exp_cnt16 = (exp_cnt16 + 1 > 65535) ? 65535 : exp_cnt16 + 1;
            exp_cnt3  = (exp_cnt3 + 1 > 7) ? 7 : exp_cnt3 + 1;
        end else if (!freeze) begin
            exp_ins   = in_r;
            exp_valid = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},    pcOut,           exp_ins.pc);
        check({tag, ".r1"},    reg1ValOut,      exp_ins.r1);
        check({tag, ".r2"},    reg2ValOut,      exp_ins.r2);
        check({tag, ".imm"},   32'(immediateOut),    32'(exp_ins.imm));
        check({tag, ".sh"},    32'(shiftOperandOut), 32'(exp_ins.sh));
        check({tag, ".simm"},  32'(signedImm24Out),  32'(exp_ins.simm));
        check({tag, ".alu"},   32'(aluCmdOut),  32'(exp_ins.alu));
        check({tag, ".ctl"},   32'({memReadOut, memWriteOut, wbEnableOut, branchOut, statusUpdateOut}),
                               32'({exp_ins.mr, exp_ins.mw, exp_ins.wb, exp_ins.br, exp_ins.su}));
        check({tag, ".regs"},  32'({destOut, src1Out, src2Out, statusOut}),
                               32'({exp_ins.dst, exp_ins.s1, exp_ins.s2, exp_ins.st}));
        check({tag, ".memen"}, 32'(memEnableOut), 32'(exp_ins.mr | exp_ins.mw));
        check({tag, ".valid"}, 32'(validOut),     32'(exp_valid));
        check({tag, ".cnt"},   32'(bubbleCount),  exp_cnt16);
        check({tag, ".cnt3"},  32'(s_cnt),        exp_cnt3);
        check({tag, ".inv"},   32'(!validOut && (memReadOut | memWriteOut | memEnableOut |
                                    wbEnableOut | branchOut | statusUpdateOut)), 32'(0));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic randomize_inputs();
        in_r.pc   = $urandom;
        in_r.r1   = $urandom;
        in_r.r2   = $urandom;
        in_r.imm  = 1'($urandom);
        in_r.sh   = 12'($urandom);
        in_r.simm = 24'($urandom);
        in_r.alu  = 4'($urandom);
        in_r.mr   = 1'($urandom);
        in_r.mw   = 1'($urandom);
        in_r.wb   = 1'($urandom);
        in_r.br   = 1'($urandom);
        in_r.su   = 1'($urandom);
        in_r.dst  = 4'($urandom);
        in_r.s1   = 4'($urandom);
        in_r.s2   = 4'($urandom);
        in_r.st   = 4'($urandom);
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; idValid = 1'b0; in_r = '0;
        model_reset();
        #12;
        compare_all("reset");
        rst = 1'b1;

        // Load all-ones, then reset asynchronously mid-cycle.
        in_r = '1; idValid = 1'b1;
        step("ones");
        #2;
        freeze = 1'b1; flush = 1'b1; rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #1;
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;

        randomize_inputs();
        in_r.r2 = 32'hDEADBEEF; in_r.sh = 12'h3FF; idValid = 1'b1;
        step("first");
        check("first.r2", reg2ValOut, 32'hDEADBEEF);
        check("first.sh", 32'(shiftOperandOut), 32'h3FF);

        in_r.mr = 1'b1; in_r.mw = 1'b0;
        step("memen1");
        check("memen1.direct", 32'(memEnableOut), 32'd1);
        in_r.mr = 1'b0; in_r.mw = 1'b0;
        step("memen0");
        check("memen0.direct", 32'(memEnableOut), 32'd0);

        in_r.alu = 4'h4; in_r.dst = 4'h7;
        step("frz_load");
        freeze = 1'b1; in_r.alu = 4'h2; in_r.dst = 4'h1;
        for (int i = 0; i < 3; i++) begin
            step("frz_hold");
            check("frz.alu", 32'(aluCmdOut), 32'h4);
            check("frz.dst", 32'(destOut), 32'h7);
        end
        freeze = 1'b0;
        step("frz_rel");
        check("frz_rel.alu", 32'(aluCmdOut), 32'h2);

        randomize_inputs();
        in_r.wb = 1'b1; in_r.br = 1'b1;
        step("fl_load");
        flush = 1'b1; freeze = 1'b1;
        step("fl_prio");
        check("fl_prio.cnt", 32'(bubbleCount), 32'd1);
        flush = 1'b0; freeze = 1'b0;

        // Bubble insertion from a fresh reset, then 3-bit saturation.
        #2; rst = 1'b0; #1; model_reset(); #1; rst = 1'b1;
        idValid = 1'b0;
        for (int i = 0; i < 5; i++) step("bub");
        check("bub5.cnt", 32'(bubbleCount), 32'd5);
        for (int i = 0; i < 5; i++) step("sat");
        check("sat.cnt3", 32'(s_cnt), 32'd7);
        step("sat_hold");
        check("sat_hold.cnt3", 32'(s_cnt), 32'd7);

        for (int i = 0; i < 2000; i++) begin
            randomize_inputs();
            flush   = ($urandom_range(0, 99) < 12);
            freeze  = ($urandom_range(0, 99) < 25);
            idValid = ($urandom_range(0, 99) < 75);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Pipeline register between the decode stage and the execute stage. It captures the decoded operands, the 12-bit shift operand, the immediate flag and the control bits each cycle, and presents them to the execute stage: the operand-2 generator, ALU and branch-target adder. It supports hazard freeze, branch flush and bubble insertion, and keeps a saturating bubble counter for performance debug.

## Interface
Parameters:
- BUBBLE_CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- freeze  in  1  hazard stall; hold all registered state
- flush  in  1  taken branch resolved in EX; squash captured instruction
- idValid  in  1  decode stage presents a real instruction
- pcIn  in  32  PC+4 of decoded instruction
- reg1ValIn, reg2ValIn  in  32 each  register-file read values
- immediateIn  in  1  I bit
- shiftOperandIn  in  12  instruction bits [11:0]
- signedImm24In  in  24  branch offset field
- aluCmdIn  in  4  execute command
- memReadIn, memWriteIn, wbEnableIn, branchIn, statusUpdateIn  in  1 each  control bits
- destIn, src1In, src2In  in  4 each  register numbers
- statusIn  in  4  NZCV at decode time
- pcOut, reg1ValOut, reg2ValOut, immediateOut, shiftOperandOut, signedImm24Out, aluCmdOut, memReadOut, memWriteOut, wbEnableOut, branchOut, statusUpdateOut, destOut, src1Out, src2Out, statusOut  out  same widths  registered copies
- memEnableOut  out  1  registered memReadIn | memWriteIn
- validOut  out  1  EX holds a real instruction
- bubbleCount  out  BUBBLE_CNT_W  cycles EX held a bubble since reset, saturating

## Operation
- Reset (rst=0, asynchronous): every output is 0, including bubbleCount. The outputs stay 0 until the first rising edge with rst=1.
- Each rising edge with rst=1 takes exactly one action, in this priority order:
  1. flush=1: load a bubble. Every control output goes to 0 (memRead, memWrite, memEnable, wbEnable, branch, statusUpdate, valid). All datapath fields also go to 0. Flush overrides freeze.
  2. freeze=1: hold every register, including validOut.
  3. idValid=0: load a bubble, same as flush.
  4. Otherwise: capture all inputs. memEnableOut = memReadIn | memWriteIn. validOut = 1.
- Bubble semantics: when validOut=0, all control outputs are 0. This invariant holds in every state, so downstream logic needs no validOut gating.
- shiftOperandOut and immediateOut pass through unmodified. Sign extension and rotation happen downstream.
- bubbleCount increments by 1 on each edge where validOut is 0 after the edge. It does not increment on a freeze edge. It saturates at 2^BUBBLE_CNT_W - 1 and does not wrap. It is cleared only by reset.

## Timing
- Latency: 1 cycle from input to output. There is no combinational path from any input to any output.
- freeze, flush and idValid are sampled only at the rising edge. Mid-cycle glitches have no effect.
- Freeze lasting N cycles: the outputs are identical for N+1 consecutive cycles.
- flush and freeze both high: flush wins; the output is a bubble on the next cycle.
- Reset asserted mid-freeze or mid-flush: the outputs clear immediately and asynchronously. After release, the first edge follows the normal priority rules.
- Counter at saturation with a bubble edge: the count stays at its maximum.

## Test plan
- Reset: drive all inputs to 1s and pull rst low mid-cycle -> all outputs are 0 immediately, before the next edge. Release, then apply idValid=1 with reg2ValIn=0xDEADBEEF and shiftOperandIn=0x3FF -> the next cycle shows reg2ValOut=0xDEADBEEF, shiftOperandOut=0x3FF, validOut=1.
- memEnable: memReadIn=1, memWriteIn=0 -> memEnableOut=1. Both inputs 0 -> memEnableOut=0 on the following cycle.
- Freeze: load aluCmdIn=0x4 and destIn=0x7, then hold freeze=1 for 3 cycles while the inputs change to aluCmdIn=0x2 and destIn=0x1 -> outputs stay at 0x4/0x7 for 4 cycles total and bubbleCount does not change. Release -> the outputs become 0x2/0x1.
- Flush priority: load an instruction with wbEnableIn=1 and branchIn=1, then assert flush=1 and freeze=1 together -> the next cycle shows wbEnableOut=0, branchOut=0, validOut=0, all datapath outputs 0, and bubbleCount increments by 1.
- Bubble insertion: set idValid=0 for 5 edges after reset -> validOut=0 and bubbleCount=5.
- Saturation: with BUBBLE_CNT_W=3, run 10 bubble edges -> bubbleCount=7 and it stays at 7.
